// File: rtl/resource_spend_ctrl_pkg.sv
// Shared definitions for the resource spend controller.
//   - Pool widths and the request amount width.
//   - Request kind encoding (energy / tracer / fluid / reserved).
//   - Controller FSM state encoding.
//   - pool_max(): all-ones value of the selected pool, zero-extended to E_W.
package resource_spend_ctrl_pkg;

    localparam int E_W   = 8;
    localparam int T_W   = 6;
    localparam int F_W   = 4;
    localparam int AMT_W = 8;

    typedef enum logic [1:0] {
        KIND_ENERGY = 2'd0,
        KIND_TRACER = 2'd1,
        KIND_FLUID  = 2'd2,
        KIND_RSVD   = 2'd3
    } req_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [E_W-1:0] pool_max(input req_kind_e kind);
        case (kind)
            KIND_ENERGY: return {E_W{1'b1}};
            KIND_TRACER: return {{(E_W-T_W){1'b0}}, {T_W{1'b1}}};
            KIND_FLUID:  return {{(E_W-F_W){1'b0}}, {F_W{1'b1}}};
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/resource_spend_ctrl_if.sv
// Request/response channel of the resource spend controller.
//   master : requester side (drives req_*, receives req_ready and rsp_*)
//   slave  : controller side
// Signals:
//   req_valid / req_ready    accept handshake
//   req_kind                 pool select (see req_kind_e)
//   req_refill               1 = add amount, 0 = spend amount
//   req_amount               units to spend or add
//   rsp_valid                1-cycle response pulse
//   rsp_granted              1 = request applied
//   rsp_remaining            pool value after the request, zero-extended
interface resource_spend_ctrl_if;
    import resource_spend_ctrl_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_kind;
    logic             req_refill;
    logic [AMT_W-1:0] req_amount;
    logic             rsp_valid;
    logic             rsp_granted;
    logic [E_W-1:0]   rsp_remaining;

    modport master (
        output req_valid, req_kind, req_refill, req_amount,
        input  req_ready, rsp_valid, rsp_granted, rsp_remaining
    );

    modport slave (
        input  req_valid, req_kind, req_refill, req_amount,
        output req_ready, rsp_valid, rsp_granted, rsp_remaining
    );

endinterface

// File: rtl/resource_spend_ctrl_alu.sv
// resource_alu: W-bit add/subtract unit used by the spend controller.
// Ports:
//   a        pool value (narrower pools zero-extended)
//   b        request amount
//   max_val  saturation limit for add (pool all-ones value, zero-extended)
//   sub      1 = a - b, 0 = a + b saturated to max_val
//   result   difference, or saturated sum
//   cout     sub: 1 = no borrow (b <= a); add: 1 = sum exceeded max_val
module resource_alu #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] max_val,
    input  logic         sub,
    output logic [W-1:0] result,
    output logic         cout
);

    // Checking the full W+1 bit sum against the limit covers both a true
    // carry-out and a narrow pool overflowing inside the wider datapath.
    function automatic logic [W-1:0] sat_to_max(input logic [W:0] raw,
                                                input logic [W-1:0] lim);
        return (raw > {1'b0, lim}) ? lim : raw[W-1:0];
    endfunction

    logic [W:0] diff;
    logic [W:0] sum;

    always_comb begin
        diff = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        sum  = {1'b0, a} + {1'b0, b};
        if (sub) begin
            result = diff[W-1:0];
            cout   = diff[W];
        end else begin
            result = sat_to_max(sum, max_val);
            cout   = (sum > {1'b0, max_val});
        end
    end

endmodule

// File: rtl/resource_spend_ctrl.sv
// resource_spend_ctrl: arbitrates spend/refill requests against the energy,
// tracer and fluid pools and drives the pool registers' load/enable inputs.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   bus (slave)                request/response channel
//   energy_q/tracer_q/fluid_q  current pool values
//   energy_en/tracer_en/fluid_en  pool write enables (1-cycle, one-hot)
//   pool_load                  new pool value; narrower pools use the low bits
// Flow: IDLE (accept) -> CALC -> [WRITE] -> RESP -> IDLE. All outputs registered.
module resource_spend_ctrl
    import resource_spend_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    resource_spend_ctrl_if.slave  bus,
    input  logic [E_W-1:0]        energy_q,
    input  logic [T_W-1:0]        tracer_q,
    input  logic [F_W-1:0]        fluid_q,
    output logic                  energy_en,
    output logic                  tracer_en,
    output logic                  fluid_en,
    output logic [E_W-1:0]        pool_load
);

    state_e           state;
    req_kind_e        kind_p0;
    logic             refill_p0;
    logic [AMT_W-1:0] amount_p0;

    logic [E_W-1:0]   pool_cur;
    logic [E_W-1:0]   pool_lim;
    logic [E_W-1:0]   alu_res;
    logic             alu_cout;
    logic             amt_ovf;
    logic             grant;
    logic [E_W-1:0]   new_val;
    logic             do_write;

    // Stage p0: request latch, captured on the accept edge
    always_ff @(posedge clk) begin
        if (!reset && state == ST_IDLE && bus.req_valid && bus.req_ready) begin
            kind_p0   <= req_kind_e'(bus.req_kind);
            refill_p0 <= bus.req_refill;
            amount_p0 <= bus.req_amount;
        end
    end

    // Stage p1: pool select and new-value computation during CALC
    always_comb begin
        case (kind_p0)
            KIND_ENERGY: pool_cur = energy_q;
            KIND_TRACER: pool_cur = {{(E_W-T_W){1'b0}}, tracer_q};
            KIND_FLUID:  pool_cur = {{(E_W-F_W){1'b0}}, fluid_q};
            default:     pool_cur = '0;
        endcase
    end

    assign pool_lim = pool_max(kind_p0);
    // Amount bits above E_W can never fit in any pool.
    assign amt_ovf  = (amount_p0 >> E_W) != '0;

    resource_alu #(
        .W (E_W)
    ) u_alu (
        .a       (pool_cur),
        .b       (amount_p0[E_W-1:0]),
        .max_val (pool_lim),
        .sub     (!refill_p0),
        .result  (alu_res),
        .cout    (alu_cout)
    );

    always_comb begin
        if (kind_p0 == KIND_RSVD) begin
            grant = 1'b0;
        end else if (refill_p0) begin
            grant = 1'b1;
        end else begin
            grant = !amt_ovf && alu_cout;
        end
    end

    assign new_val  = (refill_p0 && amt_ovf) ? pool_lim : alu_res;
    assign do_write = grant && (amount_p0 != '0);

    // Stage p2: FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            bus.req_ready     <= 1'b0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_granted   <= 1'b0;
            bus.rsp_remaining <= '0;
            energy_en         <= 1'b0;
            tracer_en         <= 1'b0;
            fluid_en          <= 1'b0;
            pool_load         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        state         <= ST_CALC;
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                ST_CALC: begin
                    bus.rsp_granted <= grant;
                    if (do_write) begin
                        // The written value is what the pool will hold during RESP.
                        pool_load         <= new_val;
                        bus.rsp_remaining <= new_val;
                        energy_en         <= (kind_p0 == KIND_ENERGY);
                        tracer_en         <= (kind_p0 == KIND_TRACER);
                        fluid_en          <= (kind_p0 == KIND_FLUID);
                        state             <= ST_WRITE;
                    end else begin
                        // pool_cur is zero for the reserved kind.
                        bus.rsp_remaining <= pool_cur;
                        bus.rsp_valid     <= 1'b1;
                        state             <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    energy_en     <= 1'b0;
                    tracer_en     <= 1'b0;
                    fluid_en      <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resource_spend_ctrl.sv
// Self-checking bench for resource_spend_ctrl. The bench owns the three pool
// registers (loaded by the DUT enables or preset by the bench) and a
// behavioural model of the pool arithmetic.
module tb_resource_spend_ctrl;
    import resource_spend_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    resource_spend_ctrl_if bus();

    logic [E_W-1:0] pe;
    logic [T_W-1:0] pt;
    logic [F_W-1:0] pf;
    logic energy_en, tracer_en, fluid_en;
    logic [E_W-1:0] pool_load;

    logic           preset_en;
    logic [E_W-1:0] pre_e;
    logic [T_W-1:0] pre_t;
    logic [F_W-1:0] pre_f;

    int n_checks = 0;
    int n_fail   = 0;
    int me, mt, mf;

    resource_spend_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .energy_q  (pe),
        .tracer_q  (pt),
        .fluid_q   (pf),
        .energy_en (energy_en),
        .tracer_en (tracer_en),
        .fluid_en  (fluid_en),
        .pool_load (pool_load)
    );

    always @(posedge clk) begin
        if (preset_en) begin
            pe <= pre_e; pt <= pre_t; pf <= pre_f;
        end else begin
            if (energy_en) pe <= pool_load;
            if (tracer_en) pt <= pool_load[T_W-1:0];
            if (fluid_en)  pf <= pool_load[F_W-1:0];
        end
    end

    typedef struct {
        bit grant; bit wr; int newv; int rem; int mask;
    } exp_t;

    typedef struct {
        bit timeout; int lat; int mask; int en_cnt; int load;
        bit granted; int rem; bit multi_en; bit busy_bad; int rsp_cnt;
    } obs_t;

    // Pool arithmetic straight from the rules: spend if it fits, refill clamps.
    function automatic exp_t model(input int kind, input bit refill, input int amt);
        exp_t e;
        int pool, maxv;
        e = '{default: 0};
        case (kind)
            0:       begin pool = me; maxv = (1 << E_W) - 1; end
            1:       begin pool = mt; maxv = (1 << T_W) - 1; end
            2:       begin pool = mf; maxv = (1 << F_W) - 1; end
            default: begin pool = 0;  maxv = 0; end
        endcase
        if (kind == 3) begin
            e.grant = 0; e.rem = 0;
        end else if (amt == 0) begin
            e.grant = 1; e.rem = pool;
        end else if (refill) begin
            e.grant = 1; e.wr = 1;
            e.newv = (pool + amt > maxv) ? maxv : pool + amt;
            e.rem = e.newv;
        end else if (amt <= pool) begin
            e.grant = 1; e.wr = 1; e.newv = pool - amt; e.rem = e.newv;
        end else begin
            e.grant = 0; e.rem = pool;
        end
        e.mask = e.wr ? (1 << kind) : 0;
        return e;
    endfunction

    task automatic commit(input exp_t e, input int kind);
        if (e.wr) begin
            if (kind == 0) me = e.newv;
            if (kind == 1) mt = e.newv;
            if (kind == 2) mf = e.newv;
        end
    endtask

    task automatic set_pools(input int e, input int t, input int f);
        @(negedge clk);
        pre_e = E_W'(e); pre_t = T_W'(t); pre_f = F_W'(f);
        preset_en = 1'b1;
        @(negedge clk);
        preset_en = 1'b0;
        me = e; mt = t; mf = f;
    endtask

    // Issues one request and records what the DUT does over the next cycles.
    // lat is the number of cycles from the accept edge to the rsp_valid cycle.
    task automatic run_req(input int kind, input bit refill, input int amt, output obs_t o);
        int guard;
        int en_n;
        o = '{default: 0};
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_kind   = 2'(kind);
        bus.req_refill = refill;
        bus.req_amount = AMT_W'(amt);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            o.timeout = 1;
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            en_n = int'(energy_en) + int'(tracer_en) + int'(fluid_en);
            if (en_n > 1) o.multi_en = 1;
            if (en_n > 0) begin
                o.en_cnt += en_n;
                o.mask |= int'({fluid_en, tracer_en, energy_en});
                o.load = int'(pool_load);
            end
            if ((o.rsp_cnt == 0 || bus.rsp_valid) && bus.req_ready) o.busy_bad = 1;
            if (bus.rsp_valid) begin
                o.rsp_cnt++;
                if (o.lat == 0) begin
                    o.lat = k - 1;
                    o.granted = bus.rsp_granted;
                    o.rem = int'(bus.rsp_remaining);
                end
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_kind = 2'd0; bus.req_refill = 1'b1; bus.req_amount = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        n_checks++; if ({energy_en, tracer_en, fluid_en} !== 3'b000) begin n_fail++; $display("FAIL rst_en: got %b want 000", {energy_en, tracer_en, fluid_en}); end
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_granted !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got v=%b g=%b want 0 0", bus.rsp_valid, bus.rsp_granted); end
        n_checks++; if (pool_load !== '0 || bus.rsp_remaining !== '0) begin n_fail++; $display("FAIL rst_data: got load=%0d rem=%0d want 0 0", pool_load, bus.rsp_remaining); end
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", bus.req_ready); end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid || energy_en || tracer_en || fluid_en) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rst_with_valid_accepted: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_energy_spend();
        obs_t o;
        set_pools(255, 0, 0);
        run_req(0, 0, 10, o);
        n_checks++; if (o.timeout || o.lat !== 2) begin n_fail++; $display("FAIL e_spend_lat: got %0d (to=%0d) want 2", o.lat, o.timeout); end
        n_checks++; if (o.mask !== 1 || o.en_cnt !== 1) begin n_fail++; $display("FAIL e_spend_en: got mask=%0d cnt=%0d want 1 1", o.mask, o.en_cnt); end
        n_checks++; if (o.load !== 245) begin n_fail++; $display("FAIL e_spend_load: got %0d want 245", o.load); end
        n_checks++; if (o.granted !== 1'b1 || o.rem !== 245) begin n_fail++; $display("FAIL e_spend_rsp: got g=%0d rem=%0d want 1 245", o.granted, o.rem); end
        n_checks++; if (int'(pe) !== 245) begin n_fail++; $display("FAIL e_spend_pool: got %0d want 245", pe); end
    endtask

    task automatic test_insufficient();
        obs_t o;
        set_pools(100, 5, 3);
        run_req(1, 0, 6, o);
        n_checks++; if (o.mask !== 0 || o.lat !== 1) begin n_fail++; $display("FAIL t_short_en: got mask=%0d lat=%0d want 0 1", o.mask, o.lat); end
        n_checks++; if (o.granted !== 1'b0 || o.rem !== 5) begin n_fail++; $display("FAIL t_short_rsp: got g=%0d rem=%0d want 0 5", o.granted, o.rem); end
        set_pools(100, 63, 3);
        run_req(1, 0, 64, o);
        n_checks++; if (o.mask !== 0 || o.granted !== 1'b0 || o.rem !== 63) begin n_fail++; $display("FAIL t_64_deny: got mask=%0d g=%0d rem=%0d want 0 0 63", o.mask, o.granted, o.rem); end
        n_checks++; if (int'(pt) !== 63) begin n_fail++; $display("FAIL t_64_pool: got %0d want 63", pt); end
    endtask

    task automatic test_refill_saturate();
        obs_t o;
        set_pools(200, 10, 14);
        run_req(2, 1, 5, o);
        n_checks++; if (o.mask !== 4 || o.load !== 15) begin n_fail++; $display("FAIL f_sat: got mask=%0d load=%0d want 4 15", o.mask, o.load); end
        n_checks++; if (o.granted !== 1'b1 || o.rem !== 15) begin n_fail++; $display("FAIL f_sat_rsp: got g=%0d rem=%0d want 1 15", o.granted, o.rem); end
        run_req(0, 1, 100, o);
        n_checks++; if (o.mask !== 1 || o.load !== 255 || o.rem !== 255) begin n_fail++; $display("FAIL e_sat: got mask=%0d load=%0d rem=%0d want 1 255 255", o.mask, o.load, o.rem); end
    endtask

    task automatic test_edge_amounts();
        obs_t o;
        set_pools(77, 20, 9);
        run_req(0, 0, 0, o);
        n_checks++; if (o.lat !== 1 || o.mask !== 0) begin n_fail++; $display("FAIL zero_amt_flow: got lat=%0d mask=%0d want 1 0", o.lat, o.mask); end
        n_checks++; if (o.granted !== 1'b1 || o.rem !== 77) begin n_fail++; $display("FAIL zero_amt_rsp: got g=%0d rem=%0d want 1 77", o.granted, o.rem); end
        run_req(3, 1, 9, o);
        n_checks++; if (o.lat !== 1 || o.mask !== 0) begin n_fail++; $display("FAIL rsvd_flow: got lat=%0d mask=%0d want 1 0", o.lat, o.mask); end
        n_checks++; if (o.granted !== 1'b0 || o.rem !== 0) begin n_fail++; $display("FAIL rsvd_rsp: got g=%0d rem=%0d want 0 0", o.granted, o.rem); end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        int kind, amt;
        bit refill;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) set_pools(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
            kind = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            refill = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       amt = 0;
                1:       amt = int'($urandom_range(1, 16));
                default: amt = int'($urandom_range(0, 255));
            endcase
            e = model(kind, refill, amt);
            run_req(kind, refill, amt, o);
            commit(e, kind);
            n_checks++; if (o.timeout || o.lat !== (e.wr ? 2 : 1) || o.rsp_cnt !== 1) begin n_fail++; $display("FAIL rnd%0d_lat: got lat=%0d rsps=%0d want %0d 1", i, o.lat, o.rsp_cnt, e.wr ? 2 : 1); end
            n_checks++; if (o.mask !== e.mask || o.en_cnt !== int'(e.wr)) begin n_fail++; $display("FAIL rnd%0d_en: got mask=%0d cnt=%0d want %0d %0d", i, o.mask, o.en_cnt, e.mask, e.wr); end
            if (e.wr) begin
                n_checks++; if (o.load !== e.newv) begin n_fail++; $display("FAIL rnd%0d_load: got %0d want %0d", i, o.load, e.newv); end
            end
            n_checks++; if (o.granted !== e.grant || o.rem !== e.rem) begin n_fail++; $display("FAIL rnd%0d_rsp k=%0d r=%0d a=%0d: got g=%0d rem=%0d want %0d %0d", i, kind, refill, amt, o.granted, o.rem, e.grant, e.rem); end
            n_checks++; if (o.multi_en || o.busy_bad) begin n_fail++; $display("FAIL rnd%0d_proto: got multi=%0d busy_ready=%0d want 0 0", i, o.multi_en, o.busy_bad); end
            n_checks++; if (int'(pe) !== me || int'(pt) !== mt || int'(pf) !== mf) begin n_fail++; $display("FAIL rnd%0d_pools: got %0d/%0d/%0d want %0d/%0d/%0d", i, pe, pt, pf, me, mt, mf); end
        end
    endtask

    task automatic test_reset_mid_op();
        obs_t o;
        int bad;
        set_pools(100, 30, 7);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_kind = 2'd0; bus.req_refill = 1'b0; bus.req_amount = 8'd1;
        bad = 0;
        while (!bus.req_ready && bad < 20) begin @(negedge clk); bad++; end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (energy_en !== 1'b1) begin n_fail++; $display("FAIL midrst_write_phase: got en=%b want 1", energy_en); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if ({energy_en, tracer_en, fluid_en, bus.rsp_valid, bus.req_ready, bus.rsp_granted} !== 6'b0) begin n_fail++; $display("FAIL midrst_outputs: got %b want 000000", {energy_en, tracer_en, fluid_en, bus.rsp_valid, bus.req_ready, bus.rsp_granted}); end
        n_checks++; if (pool_load !== '0 || bus.rsp_remaining !== '0) begin n_fail++; $display("FAIL midrst_data: got load=%0d rem=%0d want 0 0", pool_load, bus.rsp_remaining); end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid || energy_en || tracer_en || fluid_en) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_aborted: got %0d active cycles want 0", bad); end
        set_pools(50, 30, 7);
        run_req(1, 0, 12, o);
        n_checks++; if (o.lat !== 2 || o.mask !== 2 || o.load !== 18 || o.granted !== 1'b1 || o.rem !== 18) begin n_fail++; $display("FAIL midrst_next: got lat=%0d mask=%0d load=%0d g=%0d rem=%0d want 2 2 18 1 18", o.lat, o.mask, o.load, o.granted, o.rem); end
        mt = 18;
    endtask

    task automatic test_back_to_back();
        int kinds[3];
        int amts[3];
        int acc[3];
        exp_t q[$];
        exp_t e;
        int idx, rsp, en_n;
        bit pend;
        set_pools(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
        for (int i = 0; i < 3; i++) begin
            kinds[i] = int'($urandom_range(0, 2));
            amts[i] = int'($urandom_range(1, 255));
            acc[i] = -100;
        end
        idx = 0; rsp = 0; pend = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_kind = 2'(kinds[0]); bus.req_refill = 1'b1; bus.req_amount = AMT_W'(amts[0]);
        for (int cyc = 0; cyc < 40 && rsp < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (pend) begin
                pend = 0;
                if (idx < 3) begin
                    bus.req_kind = 2'(kinds[idx]); bus.req_amount = AMT_W'(amts[idx]);
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            en_n = int'(energy_en) + int'(tracer_en) + int'(fluid_en);
            if (q.size() > 0) begin
                n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready cyc%0d: got 1 want 0", cyc); end
            end
            if (en_n > 0) begin
                n_checks++;
                if (q.size() == 0) begin n_fail++; $display("FAIL b2b_stray_en cyc%0d: got en with no request in flight", cyc); end
                else if (int'({fluid_en, tracer_en, energy_en}) !== q[0].mask || int'(pool_load) !== q[0].newv) begin
                    n_fail++; $display("FAIL b2b_write cyc%0d: got mask=%0d load=%0d want %0d %0d", cyc, {fluid_en, tracer_en, energy_en}, pool_load, q[0].mask, q[0].newv);
                end
            end
            if (bus.rsp_valid) begin
                n_checks++;
                if (q.size() == 0) begin n_fail++; $display("FAIL b2b_stray_rsp cyc%0d: got rsp with no request in flight", cyc); end
                else begin
                    if (bus.rsp_granted !== 1'b1 || int'(bus.rsp_remaining) !== q[0].rem) begin
                        n_fail++; $display("FAIL b2b_rsp%0d: got g=%0d rem=%0d want 1 %0d", rsp, bus.rsp_granted, bus.rsp_remaining, q[0].rem);
                    end
                    void'(q.pop_front());
                end
                rsp++;
            end
            if (bus.req_ready && bus.req_valid && idx < 3) begin
                acc[idx] = cyc;
                e = model(kinds[idx], 1'b1, amts[idx]);
                commit(e, kinds[idx]);
                q.push_back(e);
                idx++;
                pend = 1;
            end
        end
        bus.req_valid = 1'b0;
        n_checks++; if (rsp !== 3) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 3", rsp); end
        n_checks++; if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d,%0d want 4,4", acc[1] - acc[0], acc[2] - acc[1]); end
        n_checks++; if (int'(pe) !== me || int'(pt) !== mt || int'(pf) !== mf) begin n_fail++; $display("FAIL b2b_pools: got %0d/%0d/%0d want %0d/%0d/%0d", pe, pt, pf, me, mt, mf); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        preset_en = 1'b0;
        pre_e = '0; pre_t = '0; pre_f = '0;
        bus.req_valid = 1'b0; bus.req_kind = 2'd0; bus.req_refill = 1'b0; bus.req_amount = '0;
        me = 0; mt = 0; mf = 0;
        test_reset();
        test_energy_spend();
        test_insufficient();
        test_refill_saturate();
        test_edge_amounts();
        test_random();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
